// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad-side request/result signals plus the processor memory port.
// master = sequencer side, slave = calculator front-end / processor side.
interface calc_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPC_W  = 4
);
  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] resultadoCalcu;
  logic [DATA_W-1:0] EntradaCalcu;
  logic [31:0]       addressCalcu;
  logic              writeEnableCalcu;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              err;

  modport master (
    input  start, op_a, op_b, opcode, resultadoCalcu,
    output EntradaCalcu, addressCalcu, writeEnableCalcu, busy, result, result_valid, err
  );

  modport slave (
    output start, op_a, op_b, opcode, resultadoCalcu,
    input  EntradaCalcu, addressCalcu, writeEnableCalcu, busy, result, result_valid, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: loads A, B and opcode into processor data memory, waits, then captures the result.
// Build option CALC_CLEAR_OP_EN adds a CLR write that zeroes the opcode word after capture.
module calc_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned ADDR_A      = 16,
  parameter int unsigned ADDR_B      = 20,
  parameter int unsigned ADDR_OP     = 0,
  parameter int unsigned WAIT_CYCLES = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  calc_sequencer_if.master bus
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_GAP_A, S_WR_B, S_GAP_B, S_WR_OP, S_WAIT, S_CAPTURE, S_CLR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] b_q;
  logic [OPC_W-1:0]  opc_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept_c;
  logic              reject_c;
  logic [31:0]       addr_d;
  logic [DATA_W-1:0] data_d;
  logic              we_d;
  logic              busy_d;
  logic [DATA_W-1:0] result_d;
  logic              valid_d;

  assign accept_c = (state == S_IDLE) && bus.start && (bus.opcode != '0);
  assign reject_c = (state == S_IDLE) && bus.start && (bus.opcode == '0);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept_c) state_nxt = S_WR_A;
      S_WR_A:    state_nxt = S_GAP_A;
      S_GAP_A:   state_nxt = S_WR_B;
      S_WR_B:    state_nxt = S_GAP_B;
      S_GAP_B:   state_nxt = S_WR_OP;
      S_WR_OP:   state_nxt = S_WAIT;
      S_WAIT:    if (cnt == '0) state_nxt = S_CAPTURE;
`ifdef CALC_CLEAR_OP_EN
      S_CAPTURE: state_nxt = S_CLR;
`else
      S_CAPTURE: state_nxt = S_IDLE;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    addr_d   = bus.addressCalcu;
    data_d   = bus.EntradaCalcu;
    we_d     = 1'b1;
    busy_d   = (state_nxt != S_IDLE);
    result_d = bus.result;
    valid_d  = 1'b0;
    case (state_nxt)
      S_WR_A: begin
        addr_d = 32'(ADDR_A);
        data_d = bus.op_a;
        we_d   = 1'b0;
      end
      S_WR_B: begin
        addr_d = 32'(ADDR_B);
        data_d = b_q;
        we_d   = 1'b0;
      end
      S_WR_OP: begin
        addr_d = 32'(ADDR_OP);
        data_d = DATA_W'(opc_q);
        we_d   = 1'b0;
      end
      S_CAPTURE: begin
        result_d = bus.resultadoCalcu;
        valid_d  = 1'b1;
      end
`ifdef CALC_CLEAR_OP_EN
      S_CLR: begin
        addr_d = 32'(ADDR_OP);
        data_d = '0;
        we_d   = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bus.addressCalcu     <= '0;
      bus.EntradaCalcu     <= '0;
      bus.writeEnableCalcu <= 1'b1;
      bus.busy             <= 1'b0;
      bus.result           <= '0;
      bus.result_valid     <= 1'b0;
      bus.err              <= 1'b0;
    end else begin
      bus.addressCalcu     <= addr_d;
      bus.EntradaCalcu     <= data_d;
      bus.writeEnableCalcu <= we_d;
      bus.busy             <= busy_d;
      bus.result           <= result_d;
      bus.result_valid     <= valid_d;
      bus.err              <= reject_c;
    end
  end

  // Request latch and WAIT countdown; A goes straight to the bus on acceptance
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      b_q   <= '0;
      opc_q <= '0;
      cnt   <= '0;
    end else begin
      if (accept_c) begin
        b_q   <= bus.op_b;
        opc_q <= bus.opcode;
      end
      if (state == S_WR_OP)                    cnt <= CNT_W'(WAIT_CYCLES - 1);
      else if (state == S_WAIT && cnt != '0)   cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: randomized scoreboard bench for calc_sequencer with a processor memory stub.
// Honours CALC_CLEAR_OP_EN to expect the extra opcode-clear write.
module tb_calc_sequencer;

  localparam int unsigned W = 32;
`ifdef CALC_CLEAR_OP_EN
  localparam int unsigned CLR = 1;
`else
  localparam int unsigned CLR = 0;
`endif

  typedef struct { int unsigned cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int unsigned cyc; logic [31:0] val; } res_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  calc_sequencer_if #(.DATA_W(32), .OPC_W(4)) bus ();

  calc_sequencer #(
    .DATA_W(32), .OPC_W(4), .ADDR_A(16), .ADDR_B(20), .ADDR_OP(0), .WAIT_CYCLES(W)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Calculator program behaviour: result from the words held in data memory
  function automatic logic [31:0] calc(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      32'd1:   return a + b;
      32'd2:   return a - b;
      32'd3:   return a & b;
      32'd4:   return a | b;
      32'd5:   return a ^ b;
      default: return a * b;
    endcase
  endfunction

  // Processor data-memory stub (active-low write strobe)
  logic [31:0] m_op = '0, m_a = '0, m_b = '0;
  always @(posedge CLK) begin
    if (bus.writeEnableCalcu == 1'b0) begin
      case (bus.addressCalcu)
        32'd0:  m_op <= bus.EntradaCalcu;
        32'd16: m_a  <= bus.EntradaCalcu;
        32'd20: m_b  <= bus.EntradaCalcu;
        default: ;
      endcase
    end
  end
  assign bus.resultadoCalcu = calc(m_op, m_a, m_b);

  // Reference model state, in terms of edge/cycle numbers
  wr_t         wq[$];
  res_t        rq[$];
  int unsigned eq[$];
  int unsigned cur_e = 1, done_cyc = 0, free_edge = 0, rst_lo = 1, rst_hi = 0;
  logic [31:0] held = '0;
  bit          mon_en = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Request seen at edge e: accepted only if the sequencer is idle there
  task automatic model_start(input int unsigned e, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] opc);
    if (e < free_edge) return;
    if (opc == 4'd0) begin
      eq.push_back(e);
      return;
    end
    wq.push_back('{e,     32'd16, a});
    wq.push_back('{e + 2, 32'd20, b});
    wq.push_back('{e + 4, 32'd0,  32'(opc)});
    if (CLR != 0) wq.push_back('{e + 6 + W, 32'd0, 32'd0});
    rq.push_back('{e + 5 + W, calc(32'(opc), a, b)});
    cur_e     = e;
    done_cyc  = e + 5 + W + CLR;
    free_edge = done_cyc + 2;
  endtask

  task automatic step(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [3:0] opc);
    @(negedge CLK);
    #1;
    RST_N      = 1'b1;
    bus.start  = s;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.opcode = opc;
    if (s) model_start(cyc + 1, a, b, opc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, $urandom, 4'($urandom));
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_edge) step(1'b0, $urandom, $urandom, 4'($urandom));
  endtask

  task automatic do_reset(input int unsigned n);
    int unsigned e;
    @(negedge CLK);
    #1;
    RST_N     = 1'b0;
    bus.start = 1'b0;
    e         = cyc + 1;
    rst_lo    = e;
    rst_hi    = e + n - 1;
    wq.delete();
    rq.delete();
    eq.delete();
    if (done_cyc > e - 1) done_cyc = e - 1;
    free_edge = e + n;
    repeat (n - 1) @(negedge CLK);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, result or error
  wr_t         mw;
  res_t        mr;
  int unsigned me;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (cyc >= rst_lo && cyc <= rst_hi) begin
        held = '0;
        chk("reset_addr", bus.addressCalcu, 32'd0);
        chk("reset_data", bus.EntradaCalcu, 32'd0);
      end
      chk("busy", 32'(bus.busy), (cyc >= cur_e && cyc <= done_cyc) ? 32'd1 : 32'd0);
      if (bus.writeEnableCalcu !== 1'b1) begin
        if (wq.size() == 0) chk("spurious_write", 32'(bus.writeEnableCalcu), 32'd1);
        else begin
          mw = wq.pop_front();
          chk("write_cycle", cyc, mw.cyc);
          chk("write_addr", bus.addressCalcu, mw.addr);
          chk("write_data", bus.EntradaCalcu, mw.data);
        end
      end
      if (bus.result_valid !== 1'b0) begin
        if (rq.size() == 0) chk("spurious_valid", 32'(bus.result_valid), 32'd0);
        else begin
          mr = rq.pop_front();
          chk("result_cycle", cyc, mr.cyc);
          held = mr.val;
        end
      end
      chk("result", bus.result, held);
      if (bus.err !== 1'b0) begin
        if (eq.size() == 0) chk("spurious_err", 32'(bus.err), 32'd0);
        else begin
          me = eq.pop_front();
          chk("err_cycle", cyc, me);
        end
      end
    end
  end

  initial begin
    int r;
    bus.start  = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.opcode = '0;

    do_reset(3);
    mon_en = 1'b1;
    idle(20);

    // Basic sequence: 7 + 6
    step(1'b1, 32'd7, 32'd6, 4'd1);
    wait_idle();
    idle(3);

    // Reserved opcode is rejected
    step(1'b1, 32'd5, 32'd9, 4'd0);
    idle(4);

    // Starts during WAIT are ignored
    step(1'b1, 32'd3, 32'd4, 4'd2);
    idle(12);
    repeat (5) step(1'b1, 32'd99, 32'd99, 4'd1);
    wait_idle();
    idle(2);

    // Reset during GAP_B aborts before the opcode write
    step(1'b1, 32'd10, 32'd20, 4'd1);
    idle(3);
    do_reset(1);
    idle(20);

    // Start held high across the return to IDLE
    step(1'b1, 32'd100, 32'd1, 4'd2);
    for (int i = 0; i < int'(W) + 12; i++) step(1'b1, 32'(200 + i), 32'(i), 4'd3);
    wait_idle();
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) do_reset($urandom_range(1, 3));
      else if (r < 60)
        step(1'b1, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom, $urandom,
             ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      else idle(1);
    end

    wait_idle();
    idle(int'(W) + 20);
    chk("writes_outstanding", 32'(wq.size()), 32'd0);
    chk("results_outstanding", 32'(rq.size()), 32'd0);
    chk("errs_outstanding", 32'(eq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
